// File: rtl/sram_timer_slave_if.sv
// SRAM-style data port between a CPU (master) and a memory-mapped responder (slave).
interface sram_timer_slave_if;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport master (
    output sram_en,
    output sram_wen,
    output sram_addr,
    output sram_wdata,
    input  sram_rdata
  );

  modport slave (
    input  sram_en,
    input  sram_wen,
    input  sram_addr,
    input  sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/sram_timer_slave.sv
// Memory-mapped prescaled 32-bit timer with compare match, pending flag and a
// level interrupt, answering the SRAM data port within its own address window.
module sram_timer_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h1FAF_E000,
  parameter int          WIN_BITS  = 12
) (
  input  logic               clk,
  input  logic               rst,
  sram_timer_slave_if.slave  bus,
  output logic               timer_int
);

  localparam int IDX_W = WIN_BITS - 2;

  // Byte-lane merge of write data into an existing register value.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wen);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) begin
        res[8*i +: 8] = wdata[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_val[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [2:0]  r_ctrl;
  logic        r_pend;
  logic [31:0] r_presc;
  logic [31:0] r_presc_cnt;
  logic [31:0] r_rdata;

  logic             w_hit;
  logic [IDX_W-1:0] w_idx;
  logic             w_wr;
  logic             w_rd;
  logic             w_rd_miss;
  logic             w_sel_count;
  logic             w_sel_compare;
  logic             w_sel_ctrl;
  logic             w_sel_status;
  logic             w_sel_presc;
  logic             w_wr_count;
  logic             w_tick;
  logic             w_match;
  logic             w_unused_addr;
  logic [31:0]      w_rd_val;
  logic [31:0]      w_count_nxt;
  logic [31:0]      w_presc_cnt_nxt;
  logic             w_pend_nxt;

  assign w_hit         = (bus.sram_addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
  assign w_idx         = bus.sram_addr[WIN_BITS-1:2];
  assign w_unused_addr = ^bus.sram_addr[1:0];
  assign w_wr          = bus.sram_en & w_hit & (bus.sram_wen != 4'b0000);
  assign w_rd          = bus.sram_en & w_hit & (bus.sram_wen == 4'b0000);
  assign w_rd_miss     = bus.sram_en & ~w_hit & (bus.sram_wen == 4'b0000);
  assign w_sel_count   = (w_idx == IDX_W'(0));
  assign w_sel_compare = (w_idx == IDX_W'(1));
  assign w_sel_ctrl    = (w_idx == IDX_W'(2));
  assign w_sel_status  = (w_idx == IDX_W'(3));
  assign w_sel_presc   = (w_idx == IDX_W'(4));
  assign w_wr_count    = w_wr & w_sel_count;

  // A tick fires when enabled and the prescaler reaches its terminal value;
  // a software COUNT write on that cycle suppresses the match.
  assign w_tick  = r_ctrl[0] & (r_presc_cnt == r_presc);
  assign w_match = w_tick & ~w_wr_count & (r_count == r_compare);

  assign timer_int = r_pend & r_ctrl[1];

  // Read data mux over the register map; unmapped offsets read zero.
  always_comb begin
    w_rd_val = 32'h0000_0000;
    if (w_sel_count) begin
      w_rd_val = r_count;
    end else if (w_sel_compare) begin
      w_rd_val = r_compare;
    end else if (w_sel_ctrl) begin
      w_rd_val = {29'h0000_0000, r_ctrl};
    end else if (w_sel_status) begin
      w_rd_val = {31'h0000_0000, r_pend};
    end else if (w_sel_presc) begin
      w_rd_val = r_presc;
    end else begin
      w_rd_val = 32'h0000_0000;
    end
  end

  // Next COUNT: software write wins, otherwise advance (or auto-clear) on tick.
  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_count) begin
      w_count_nxt = lane_merge(r_count, bus.sram_wdata, bus.sram_wen);
    end else if (w_tick) begin
      if (w_match && r_ctrl[2]) begin
        w_count_nxt = 32'h0000_0000;
      end else begin
        w_count_nxt = r_count + 32'h0000_0001;
      end
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Next prescaler count: cleared by PRESC writes, when disabled, and on wrap.
  always_comb begin
    w_presc_cnt_nxt = r_presc_cnt;
    if (w_wr & w_sel_presc) begin
      w_presc_cnt_nxt = 32'h0000_0000;
    end else if (!r_ctrl[0]) begin
      w_presc_cnt_nxt = 32'h0000_0000;
    end else if (w_tick) begin
      w_presc_cnt_nxt = 32'h0000_0000;
    end else begin
      w_presc_cnt_nxt = r_presc_cnt + 32'h0000_0001;
    end
  end

  // Next PEND: a match sets it and beats a same-cycle write-1-to-clear.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_match) begin
      w_pend_nxt = 1'b1;
    end else if (w_wr && w_sel_status && bus.sram_wen[0] && bus.sram_wdata[0]) begin
      w_pend_nxt = 1'b0;
    end else begin
      w_pend_nxt = r_pend;
    end
  end

  // Register state update, including software writes and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= 32'h0000_0000;
      r_compare   <= 32'hFFFF_FFFF;
      r_ctrl      <= 3'b000;
      r_pend      <= 1'b0;
      r_presc     <= 32'h0000_0000;
      r_presc_cnt <= 32'h0000_0000;
      r_rdata     <= 32'h0000_0000;
    end else begin
      r_count     <= w_count_nxt;
      r_presc_cnt <= w_presc_cnt_nxt;
      r_pend      <= w_pend_nxt;
      if (w_wr && w_sel_compare) begin
        r_compare <= lane_merge(r_compare, bus.sram_wdata, bus.sram_wen);
      end
      if (w_wr && w_sel_ctrl && bus.sram_wen[0]) begin
        r_ctrl <= bus.sram_wdata[2:0];
      end
      if (w_wr && w_sel_presc) begin
        r_presc <= lane_merge(r_presc, bus.sram_wdata, bus.sram_wen);
      end
      if (w_rd) begin
        r_rdata <= w_rd_val;
      end else if (w_rd_miss) begin
        r_rdata <= 32'h0000_0000;
      end
    end
  end

  assign bus.sram_rdata = r_rdata;

endmodule

// File: tb/tb_sram_timer_slave.sv
// Directed self-checking bench for sram_timer_slave.
module tb_sram_timer_slave;

  localparam logic [31:0] BASE = 32'h1FAF_E000;
  localparam logic [31:0] A_COUNT   = BASE + 32'h00;
  localparam logic [31:0] A_COMPARE = BASE + 32'h04;
  localparam logic [31:0] A_CTRL    = BASE + 32'h08;
  localparam logic [31:0] A_STATUS  = BASE + 32'h0C;
  localparam logic [31:0] A_PRESC   = BASE + 32'h10;

  logic clk;
  logic rst;
  logic timer_int;
  int   n_checks;
  int   n_errors;
  logic [31:0] rd;

  sram_timer_slave_if bus();

  sram_timer_slave #(.BASE_ADDR(BASE), .WIN_BITS(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .timer_int (timer_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle write, issued at a falling edge, returns at the next falling edge.
  task automatic bus_write(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] data);
    bus.sram_en    = 1'b1;
    bus.sram_wen   = wen;
    bus.sram_addr  = addr;
    bus.sram_wdata = data;
    @(negedge clk);
    bus.sram_en    = 1'b0;
    bus.sram_wen   = 4'b0000;
  endtask

  // One-cycle read; data is sampled one cycle after the request.
  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus.sram_en    = 1'b1;
    bus.sram_wen   = 4'b0000;
    bus.sram_addr  = addr;
    @(negedge clk);
    bus.sram_en    = 1'b0;
    data = bus.sram_rdata;
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst            = 1'b1;
    bus.sram_en    = 1'b0;
    bus.sram_wen   = 4'b0000;
    bus.sram_addr  = 32'h0000_0000;
    bus.sram_wdata = 32'h0000_0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1. reset values
    check("rst_rdata", bus.sram_rdata, 32'h0000_0000);
    check("rst_int", {31'h0, timer_int}, 32'h0000_0000);
    bus_read(A_COMPARE, rd); check("rst_compare", rd, 32'hFFFF_FFFF);
    bus_read(A_CTRL, rd);    check("rst_ctrl", rd, 32'h0000_0000);

    // 2. compare match with interrupt, then W1C
    bus_write(A_PRESC, 4'hF, 32'd0);
    bus_write(A_COMPARE, 4'hF, 32'd5);
    bus_write(A_COUNT, 4'hF, 32'd0);
    bus_write(A_CTRL, 4'hF, 32'h3);
    repeat (5) @(negedge clk);
    check("int_before_match", {31'h0, timer_int}, 32'h0);
    @(negedge clk);
    check("int_at_match", {31'h0, timer_int}, 32'h1);
    bus_write(A_STATUS, 4'h1, 32'h1);
    check("int_after_w1c", {31'h0, timer_int}, 32'h0);
    bus_read(A_STATUS, rd); check("status_after_w1c", rd, 32'h0);
    bus_write(A_CTRL, 4'hF, 32'h0);

    // 3. prescaler of 3: one increment per 4 cycles
    bus_write(A_PRESC, 4'hF, 32'd3);
    bus_write(A_COUNT, 4'hF, 32'd0);
    bus_write(A_CTRL, 4'hF, 32'h1);
    repeat (40) @(negedge clk);
    bus_read(A_COUNT, rd); check("presc3_count", rd, 32'd10);
    check("int_masked_ie0", {31'h0, timer_int}, 32'h0);
    bus_write(A_CTRL, 4'hF, 32'h0);

    // 4. wrap then auto-clear on match
    bus_write(A_PRESC, 4'hF, 32'd0);
    bus_write(A_COMPARE, 4'hF, 32'd2);
    bus_write(A_COUNT, 4'hF, 32'hFFFF_FFFE);
    bus_write(A_STATUS, 4'h1, 32'h1);
    bus_write(A_CTRL, 4'hF, 32'h5);
    bus_read(A_COUNT, rd);  check("wrap_fffe", rd, 32'hFFFF_FFFE);
    bus_read(A_COUNT, rd);  check("wrap_ffff", rd, 32'hFFFF_FFFF);
    bus_read(A_COUNT, rd);  check("wrap_zero", rd, 32'h0000_0000);
    bus_read(A_STATUS, rd); check("pend_before_match", rd, 32'h0);
    bus_read(A_COUNT, rd);  check("count_at_match", rd, 32'd2);
    bus_read(A_COUNT, rd);  check("autoclr_count", rd, 32'd0);
    bus_read(A_STATUS, rd); check("pend_after_match", rd, 32'h1);
    bus_write(A_CTRL, 4'hF, 32'h0);

    // 5. byte lane write and window decoding
    bus_write(A_COMPARE, 4'hF, 32'hFFFF_FFFF);
    bus_write(A_COMPARE, 4'b0010, 32'hAABB_CCDD);
    bus_read(A_COMPARE, rd); check("byte_merge", rd, 32'hFFFF_CCFF);
    bus_write(A_COUNT, 4'hF, 32'd7);
    check("rdata_hold_on_write", bus.sram_rdata, 32'hFFFF_CCFF);
    bus_read(BASE + 32'h20, rd); check("unmapped_read", rd, 32'h0);
    bus_read(A_COMPARE, rd);
    bus_read(32'h0000_1004, rd); check("miss_read", rd, 32'h0);
    bus_write(32'h2000_0004, 4'hF, 32'h0);
    bus_write(BASE + 32'h20, 4'hF, 32'h0);
    bus_read(A_COMPARE, rd); check("compare_untouched", rd, 32'hFFFF_CCFF);
    bus_read(A_COUNT, rd);   check("count_untouched", rd, 32'd7);

    // 6. match and W1C on the same cycle: set wins
    bus_write(A_STATUS, 4'h1, 32'h1);
    bus_write(A_PRESC, 4'hF, 32'd0);
    bus_write(A_COMPARE, 4'hF, 32'd3);
    bus_write(A_COUNT, 4'hF, 32'd0);
    bus_write(A_CTRL, 4'hF, 32'h3);
    repeat (3) @(negedge clk);
    bus_write(A_STATUS, 4'h1, 32'h1);
    check("set_wins_int", {31'h0, timer_int}, 32'h1);
    bus_read(A_STATUS, rd); check("set_wins_pend", rd, 32'h1);
    bus_read(A_COUNT, rd);  check("count_running", rd, 32'd5);

    // reset mid-count, with a request presented during reset
    rst            = 1'b1;
    bus.sram_en    = 1'b1;
    bus.sram_wen   = 4'hF;
    bus.sram_addr  = A_COUNT;
    bus.sram_wdata = 32'h0000_1234;
    @(negedge clk);
    rst          = 1'b0;
    bus.sram_en  = 1'b0;
    bus.sram_wen = 4'b0000;
    check("midrst_rdata", bus.sram_rdata, 32'h0);
    check("midrst_int", {31'h0, timer_int}, 32'h0);
    bus_read(A_COUNT, rd);   check("midrst_count", rd, 32'h0);
    bus_read(A_COMPARE, rd); check("midrst_compare", rd, 32'hFFFF_FFFF);
    bus_read(A_CTRL, rd);    check("midrst_ctrl", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
